// File: rtl/mycpu_pkg.sv
// Shared pipeline constants and bus layouts for the EX->MEM->WB path.
// Consumed by stage_4_mem (optional MYCPU_MEM_FWD_EN bypass) and load_align.
package mycpu_pkg;

  localparam int EX_MEM_W = 74;
  localparam int MEM_WB_W = 70;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b101;
  localparam logic [2:0] LD_HU = 3'b110;

  typedef struct packed {
    logic [2:0]  ld_type;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } ex_mem_bus_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } mem_wb_bus_t;

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks byte/half by address offset and extends.
module load_align
  import mycpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (off)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = 32'h0;
    case (ld_type)
      LD_W:    result = rdata;
      LD_B:    result = {{24{w_byte[7]}}, w_byte};
      LD_BU:   result = {24'h0, w_byte};
      LD_H:    result = {{16{w_half[15]}}, w_half};
      LD_HU:   result = {16'h0, w_half};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/stage_4_mem.sv
// MEM pipeline stage: latches the EX bus, aligns SRAM load data, feeds WB.
// Define MYCPU_MEM_FWD_EN to enable the MEM->ID bypass outputs.
module stage_4_mem
  import mycpu_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid_3,
  output logic                allow_4,
  input  logic [EX_MEM_W-1:0] stage_3_to_4,
  input  logic [31:0]         data_sram_rdata,
  output logic                valid_4,
  input  logic                allow_5,
  output logic [MEM_WB_W-1:0] stage_4_to_5,
  output logic                fwd_we,
  output logic [4:0]          fwd_dest,
  output logic [31:0]         fwd_data
);

  ex_mem_bus_t r_bus;
  logic        r_valid_4;
  logic [31:0] r_hold;
  logic        r_held;

  logic        w_allow;
  logic        w_accept;
  logic [31:0] w_rdata;
  logic [31:0] w_load;
  logic [31:0] w_final;
  mem_wb_bus_t w_out;

  assign w_allow  = !r_valid_4 || allow_5;
  assign w_accept = w_allow && valid_3;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid_4 <= 1'b0;
      r_bus     <= '0;
    end else if (w_allow) begin
      r_valid_4 <= valid_3;
      r_bus     <= ex_mem_bus_t'(stage_3_to_4);
    end
  end

  // SRAM data is only valid on the first resident cycle; keep it for stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold <= 32'h0;
      r_held <= 1'b0;
    end else if (w_accept) begin
      r_held <= 1'b0;
    end else if (r_valid_4 && !r_held) begin
      r_hold <= data_sram_rdata;
      r_held <= 1'b1;
    end
  end

  assign w_rdata = r_held ? r_hold : data_sram_rdata;

  load_align u_load_align (
    .rdata   (w_rdata),
    .off     (r_bus.alu_result[1:0]),
    .ld_type (r_bus.ld_type),
    .result  (w_load)
  );

  assign w_final = r_bus.res_from_mem ? w_load : r_bus.alu_result;

  always_comb begin
    w_out              = '0;
    w_out.rf_we        = r_bus.rf_we & r_valid_4;
    w_out.dest         = r_bus.dest;
    w_out.final_result = w_final;
    w_out.pc           = r_bus.pc;
  end

  assign allow_4      = w_allow;
  assign valid_4      = r_valid_4;
  assign stage_4_to_5 = w_out;

`ifdef MYCPU_MEM_FWD_EN
  assign fwd_we   = r_bus.rf_we & r_valid_4;
  assign fwd_dest = r_bus.dest;
  assign fwd_data = w_final;
`else
  assign fwd_we   = 1'b0;
  assign fwd_dest = 5'd0;
  assign fwd_data = 32'h0;
`endif

endmodule

// File: tb/tb_stage_4_mem.sv
// Scoreboard bench for stage_4_mem: expected WB buses queued on acceptance.
module tb_stage_4_mem;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_3;
  logic        allow_5;
  logic [73:0] stage_3_to_4;
  logic [31:0] data_sram_rdata;
  logic        allow_4;
  logic        valid_4;
  logic [69:0] stage_4_to_5;
  logic        fwd_we;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;

  int          errs   = 0;
  int          checks = 0;
  logic [69:0] exq[$];
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  stage_4_mem dut (
    .clk             (clk),
    .resetn          (resetn),
    .valid_3         (valid_3),
    .allow_4         (allow_4),
    .stage_3_to_4    (stage_3_to_4),
    .data_sram_rdata (data_sram_rdata),
    .valid_4         (valid_4),
    .allow_5         (allow_5),
    .stage_4_to_5    (stage_4_to_5),
    .fwd_we          (fwd_we),
    .fwd_dest        (fwd_dest),
    .fwd_data        (fwd_data)
  );

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (ld)
      3'b000: return rd;
      3'b001: return {{24{sh[7]}}, sh[7:0]};
      3'b101: return {24'h0, sh[7:0]};
      3'b010: begin sh = rd >> (off[1] ? 16 : 0); return {{16{sh[15]}}, sh[15:0]}; end
      3'b110: begin sh = rd >> (off[1] ? 16 : 0); return {16'h0, sh[15:0]}; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [73:0] mk(input logic [2:0] ld, input logic rfm, input logic we,
                                     input logic [4:0] dest, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {ld, rfm, we, dest, alu, pc};
  endfunction

  function automatic logic [69:0] expect_of(input logic [73:0] ins, input logic [31:0] rd);
    logic [31:0] alu;
    logic [31:0] fin;
    alu = ins[63:32];
    fin = ins[70] ? ref_load(ins[73:71], alu[1:0], rd) : alu;
    return {ins[69], ins[68:64], fin, ins[31:0]};
  endfunction

  // One cycle: drive inputs, check outputs mid-cycle, advance the model on the edge.
  // km=1 compares the whole WB bus to kv, km=2 compares only final_result.
  task automatic cyc(input bit v3, input logic [73:0] ins, input logic [31:0] ins_rd,
                     input bit a5, input logic [31:0] rd_now,
                     input int km = 0, input logic [69:0] kv = '0);
    logic [69:0] exp;
    valid_3 = v3; stage_3_to_4 = ins; allow_5 = a5; data_sram_rdata = rd_now;
    #4;
    chk("allow_4", 70'(allow_4), 70'(!m_valid || a5));
    chk("valid_4", 70'(valid_4), 70'(m_valid));
    if (m_valid) begin
      exp = (exq.size() != 0) ? exq[0] : 'x;
      chk("wb_bus", stage_4_to_5, exp);
`ifdef MYCPU_MEM_FWD_EN
      chk("fwd", {32'h0, fwd_we, fwd_dest, fwd_data}, {32'h0, exp[69], exp[68:64], exp[63:32]});
`else
      chk("fwd_off", {32'h0, fwd_we, fwd_dest, fwd_data}, 70'h0);
`endif
      if (km == 1) chk("const_bus", stage_4_to_5, kv);
      if (km == 2) chk("const_final", {38'h0, stage_4_to_5[63:32]}, kv);
    end else begin
      chk("rf_we_masked", 70'(stage_4_to_5[69]), 70'h0);
      chk("fwd_we_idle", 70'(fwd_we), 70'h0);
    end
    @(posedge clk);
    if (!m_valid || a5) begin
      if (m_valid && exq.size() != 0) void'(exq.pop_front());
      m_valid = v3;
      if (v3) exq.push_back(expect_of(ins, ins_rd));
    end
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid_4"}, 70'(valid_4), 70'h0);
    chk({tag, "_allow_4"}, 70'(allow_4), 70'h1);
    chk({tag, "_bus"}, stage_4_to_5, 70'h0);
    chk({tag, "_fwd"}, {32'h0, fwd_we, fwd_dest, fwd_data}, 70'h0);
  endtask

  localparam logic [73:0] Z = 74'h0;

  initial begin
    resetn = 1'b0; valid_3 = 1'b0; allow_5 = 1'b1;
    stage_3_to_4 = mk(3'b000, 1'b0, 1'b1, 5'd3, 32'hFFFF, 32'h1); data_sram_rdata = 32'hFFFF_FFFF;
    #12;
    chk_reset_state("rst");
    resetn = 1'b1;
    valid_3 = 1'b0;
    @(posedge clk); #1;
    cyc(0, Z, 0, 1, 0);

    // ALU op
    cyc(1, mk(3'b000, 0, 1, 5'd5, 32'h1234, 32'h1c00_0000), 0, 1, 0);
    cyc(0, Z, 0, 1, 0, 1, {1'b1, 5'd5, 32'h1234, 32'h1c00_0000});

    // Loads back-to-back; rdata for each arrives the cycle after it is sent
    cyc(1, mk(3'b001, 1, 1, 5'd7, 32'h1003, 32'h1c00_0010), 32'h80FF_FF7F, 1, 0);
    cyc(1, mk(3'b101, 1, 1, 5'd8, 32'h1003, 32'h1c00_0014), 32'h80FF_FF7F, 1, 32'h80FF_FF7F,
        2, 70'hFFFF_FF80);
    cyc(1, mk(3'b010, 1, 1, 5'd9, 32'h2002, 32'h1c00_0018), 32'h8001_0000, 1, 32'h80FF_FF7F,
        2, 70'h0000_0080);
    cyc(1, mk(3'b110, 1, 1, 5'd10, 32'h2002, 32'h1c00_001c), 32'h8001_0000, 1, 32'h8001_0000,
        2, 70'hFFFF_8001);
    cyc(1, mk(3'b000, 1, 1, 5'd11, 32'h3001, 32'h1c00_0020), 32'h1234_5678, 1, 32'h8001_0000,
        2, 70'h0000_8001);
    cyc(1, mk(3'b011, 1, 1, 5'd12, 32'h3000, 32'h1c00_0024), 32'h0000_AAAA, 1, 32'h1234_5678,
        2, 70'h1234_5678);
    cyc(1, mk(3'b001, 1, 1, 5'd13, 32'h3001, 32'h1c00_0028), 32'h0000_7F00, 1, 32'h0000_AAAA,
        2, 70'h0);
    cyc(0, Z, 0, 1, 32'h0000_7F00, 2, 70'h7F);

    // Four ALU ops with no bubble, then drain
    for (int i = 0; i < 4; i++)
      cyc(1, mk(3'b000, 0, i[0], 5'(i + 1), 32'h100 + i, 32'h1c00_0100 + 4 * i), 0, 1, 0);
    cyc(0, Z, 0, 1, 0);
    cyc(0, Z, 0, 1, 0);

    // Stall with WB blocked while SRAM data changes underneath
    cyc(1, mk(3'b001, 1, 1, 5'd20, 32'h40, 32'h1c00_0200), 32'h0000_00F0, 1, 0);
    cyc(1, mk(3'b000, 0, 1, 5'd21, 32'h55, 32'h1c00_0204), 0, 0, 32'h0000_00F0, 2, 70'hFFFF_FFF0);
    for (int i = 0; i < 2; i++)
      cyc(1, mk(3'b000, 0, 1, 5'd21, 32'h55, 32'h1c00_0204), 0, 0, 32'hDEAD_BEEF,
          2, 70'hFFFF_FFF0);
    cyc(1, mk(3'b000, 0, 1, 5'd21, 32'h55, 32'h1c00_0204), 0, 1, 32'hDEAD_BEEF, 2, 70'hFFFF_FFF0);
    cyc(0, Z, 0, 1, 32'hDEAD_BEEF);

    // Reset mid-load, asynchronously
    cyc(1, mk(3'b010, 1, 1, 5'd25, 32'h80, 32'h1c00_0300), 32'h0000_9ABC, 1, 0);
    valid_3 = 1'b0; data_sram_rdata = 32'h0000_9ABC;
    #2;
    chk("pre_rst_valid", 70'(valid_4), 70'h1);
    resetn = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    exq.delete();
    m_valid = 1'b0;
    #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    cyc(0, Z, 0, 1, 0);
    cyc(1, mk(3'b000, 0, 1, 5'd30, 32'hCAFE, 32'h1c00_0400), 0, 1, 0);
    cyc(0, Z, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/stage_4_mem.md
STAGE_4_MEM -- requirements
Module: stage_4_mem

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port `resetn`: input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port `valid_3`: input, 1 bit, EX stage holds a valid instruction.
REQ-004 SHALL have port `allow_4`: output, 1 bit, this stage accepts a new instruction this cycle.
REQ-005 SHALL have port `stage_3_to_4`: input, 74 bits = {ld_type[2:0], res_from_mem, rf_we, dest[4:0], alu_result[31:0], pc[31:0]}.
REQ-006 SHALL have port `data_sram_rdata`: input, 32 bits, SRAM read data, valid exactly one cycle after the EX-stage request.
REQ-007 SHALL have port `valid_4`: output, 1 bit, this stage holds a valid instruction.
REQ-008 SHALL have port `allow_5`: input, 1 bit, WB accepts.
REQ-009 SHALL have port `stage_4_to_5`: output, 70 bits = {rf_we, dest[4:0], final_result[31:0], pc[31:0]}.
REQ-010 SHALL have ports `fwd_we` (1 bit), `fwd_dest` (5 bits) and `fwd_data` (32 bits): outputs, MEM-stage bypass to ID.

Function
REQ-011 SHALL compute `allow_4 = !valid_4 || allow_5`; ready_go is constantly 1.
REQ-012 SHALL load the bus register and set `valid_4 <= valid_3` on any edge where `allow_4` is 1; otherwise hold both.
REQ-013 SHALL clear `valid_4` when `allow_4 && !valid_3`; the bus register may keep its stale contents in that case.
REQ-014 SHALL capture `data_sram_rdata` into a hold register on the first cycle an instruction is resident, and set a `held` flag.
- `held` clears when a new instruction enters.
- The load result uses the hold register while `held` is 1, and the live rdata otherwise.
REQ-015 SHALL select the load lane by `off = alu_result[1:0]`.
- ld_type encoding: 000 = W, 001 = B, 010 = H, 101 = BU, 110 = HU.
- B/H: sign-extend; BU/HU: zero-extend.
- H/HU: use `off[1]` only.
- W: ignore `off`.
- Undefined ld_type: yield 0.
REQ-016 SHALL set `final_result` = the load result when `res_from_mem`, and `alu_result` otherwise.
REQ-017 SHALL drive `stage_4_to_5` rf_we as `rf_we & valid_4`.
REQ-018 SHALL latch a new instruction with no bubble when `valid_3`, `allow_4` and `allow_5` are all 1 on the same edge, while the old instruction leaves.
REQ-019 SHALL give a latency of exactly one cycle from `valid_3 && allow_4` to `valid_4`.

Reset
REQ-020 SHALL, on `resetn` low, asynchronously clear `valid_4`, the bus register, the hold register and `held`.
REQ-021 SHALL hold `stage_4_to_5 = 70'b0`, `valid_4 = 0`, `allow_4 = 1` and the fwd outputs at 0 while in reset.
REQ-022 SHALL discard an in-flight instruction when reset is asserted mid-operation.
REQ-023 SHALL capture nothing on the first edge after `resetn` rises unless `valid_3` is 1.

Configuration
REQ-024 SHALL support macro `MYCPU_MEM_FWD_EN`.
- Defined: `fwd_we = rf_we & valid_4`, `fwd_dest = dest`, `fwd_data = final_result`.
- Undefined: all three outputs are tied to 0 and the bypass logic is absent.

Structure
REQ-025 SHALL place the bus widths (74, 70) and the ld_type encodings as constants in the shared package `mycpu_pkg`.
REQ-026 SHALL implement lane extraction and extension in the combinational sub-module `load_align` (inputs rdata, off, ld_type; output 32 bits).

Verification
REQ-027 SHALL cover: reset, then stimulus ALU op (dest 5, alu_result 0x1234, pc 0x1c000000) -> next cycle `valid_4` = 1 and `stage_4_to_5 = {1, 5, 0x1234, 0x1c000000}`.
REQ-028 SHALL cover: ld.b, off 3, rdata 0x80FF_FF7F -> final_result 0xFFFF_FF80; ld.bu with the same inputs -> 0x0000_0080.
REQ-029 SHALL cover: ld.h, off 2, rdata 0x8001_0000 -> 0xFFFF_8001; ld.hu -> 0x0000_8001.
REQ-030 SHALL cover: load resident with `allow_5 = 0` for 3 cycles while rdata changes to 0xDEAD_BEEF -> held data is output, `allow_4` = 0, and the bus is unchanged.
REQ-031 SHALL cover: back-to-back `valid_3` for 4 cycles with `allow_5` = 1 -> 4 consecutive outputs with no bubble; then `valid_3` = 0 -> `valid_4` = 0.
REQ-032 SHALL cover: assert `resetn` low mid-load -> `valid_4` and the fwd outputs go to 0 immediately, asynchronously.
